// File: rtl/cpu_pkg.sv
// Shared types and widths for the 9-bit core: opcode encoding and fetch-stage states.
package cpu_pkg;

    localparam int PC_W     = 10;
    localparam int INSTR_W  = 9;
    localparam int OPCODE_W = 3;

    typedef enum logic [OPCODE_W-1:0] {
        ADD   = 3'd0,
        ADDI  = 3'd1,
        XOR   = 3'd2,
        LOAD  = 3'd3,
        STORE = 3'd4,
        JUMP  = 3'd5,
        CMP   = 3'd6,
        SHF   = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: OPCODE_W];
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid for the fetch stage: parks {instr, pc} on the first stalled cycle
// and, while full, overrides the live memory response on the output mux.
module fetch_hold_buf
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               capture,
    input  logic               clear,
    input  logic [INSTR_W-1:0] resp_instr,
    input  logic [PC_W-1:0]    resp_pc,
    output logic               hold_v,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc
);

    logic [INSTR_W-1:0] hold_instr_q;
    logic [PC_W-1:0]    hold_pc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_v       <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
        end else if (clear) begin
            hold_v <= 1'b0;
        end else if (capture && !hold_v) begin
            // Only the first stalled cycle loads; later cycles keep the original entry.
            hold_v       <= 1'b1;
            hold_instr_q <= resp_instr;
            hold_pc_q    <= resp_pc;
        end
    end

    assign out_instr = hold_v ? hold_instr_q : resp_instr;
    assign out_pc    = hold_v ? hold_pc_q    : resp_pc;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the 1-cycle-latency instruction memory and presents
// one instruction per cycle to decode under valid/stall, with branch redirect and halt.
module instr_fetch
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_W-1:0]     branch_target,
    input  logic                halt,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [PC_W-1:0]     pc_out,
    output logic                instr_valid,
    output logic                done
);

    fetch_state_t       state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    resp_pc_q;
    logic               resp_v_q;

    logic               running;
    logic               accept;
    logic               stalled;
    logic               hold_v;
    logic [INSTR_W-1:0] sel_instr;
    logic [PC_W-1:0]    sel_pc;

    assign running     = (state_q == RUN);
    assign instr_valid = running && (resp_v_q || hold_v);
    assign accept      = instr_valid && !stall;
    assign stalled     = instr_valid && stall;

    fetch_hold_buf u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture    (stalled),
        .clear      (accept || !running),
        .resp_instr (imem_rdata),
        .resp_pc    (resp_pc_q),
        .hold_v     (hold_v),
        .out_instr  (sel_instr),
        .out_pc     (sel_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            resp_v_q  <= 1'b0;
            resp_pc_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    resp_v_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        pc_q    <= '0;
                    end
                end
                RUN: begin
                    if (accept && halt) begin
                        state_q  <= DONE;
                        pc_q     <= '0;
                        resp_v_q <= 1'b0;
                    end else if (accept && branch_taken) begin
                        pc_q     <= branch_target;
                        resp_v_q <= 1'b0;
                    end else begin
                        // The address on the bus this cycle returns next cycle, even while
                        // stalled: the frozen PC simply re-reads the same word.
                        resp_v_q  <= 1'b1;
                        resp_pc_q <= pc_q;
                        if (!stalled) begin
                            pc_q <= pc_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    resp_v_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr = running ? pc_q : '0;
    assign done      = (state_q == DONE);
    assign instr     = instr_valid ? sel_instr : '0;
    assign pc_out    = instr_valid ? sel_pc : '0;
    assign opcode    = opcode_of(instr);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed cycle table followed by randomized traffic against a
// PC-stream model of the fetch stage.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                stall;
    logic                branch_taken;
    logic [PC_W-1:0]     branch_target;
    logic                halt;
    logic [PC_W-1:0]     imem_addr;
    logic [INSTR_W-1:0]  imem_rdata;
    logic [INSTR_W-1:0]  instr;
    logic [OPCODE_W-1:0] opcode;
    logic [PC_W-1:0]     pc_out;
    logic                instr_valid;
    logic                done;

    logic [INSTR_W-1:0]  mem [1024];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= mem[imem_addr];

    instr_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt          (halt),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .opcode        (opcode),
        .pc_out        (pc_out),
        .instr_valid   (instr_valid),
        .done          (done)
    );

    typedef struct {
        logic            rst;
        logic            st;
        logic            stl;
        logic            br;
        logic [PC_W-1:0] tgt;
        logic            hlt;
        logic            ev;
        logic [PC_W-1:0] epc;
        logic            ed;
        logic [PC_W-1:0] eaddr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic st, input logic stl, input logic br,
                       input int tgt, input logic hlt,
                       input logic ev, input int epc, input logic ed, input int eaddr);
        vec_t v;
        v.rst = rst; v.st = st; v.stl = stl; v.br = br; v.tgt = tgt[PC_W-1:0]; v.hlt = hlt;
        v.ev = ev; v.epc = epc[PC_W-1:0]; v.ed = ed; v.eaddr = eaddr[PC_W-1:0];
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic st, input logic stl, input logic br,
                         input logic [PC_W-1:0] tgt, input logic hlt);
        rst_n         = !rst;
        start         = st;
        stall         = stl;
        branch_taken  = br;
        branch_target = tgt;
        halt          = hlt;
    endtask

    // Model state: phase of the program, next PC to be presented, pending bubble.
    int              m_mode;   // 0 idle, 1 run, 2 done
    logic [PC_W-1:0] m_pc;
    logic            m_bubble;

    task automatic model_step(input logic rst, input logic st, input logic stl, input logic br,
                              input logic [PC_W-1:0] tgt, input logic hlt);
        logic vis;
        vis = (m_mode == 1) && !m_bubble;
        if (rst) begin
            m_mode = 0;
        end else if (m_mode != 1) begin
            if (st) begin
                m_mode   = 1;
                m_pc     = '0;
                m_bubble = 1'b1;
            end
        end else if (!vis) begin
            m_bubble = 1'b0;
        end else if (!stl) begin
            if (hlt) begin
                m_mode = 2;
            end else if (br) begin
                m_pc     = tgt;
                m_bubble = 1'b1;
            end else begin
                m_pc = m_pc + 1'b1;
            end
        end
    endtask

    initial begin
        logic [PC_W-1:0] tgt;
        logic            ev;
        logic            r_rst, r_st, r_stl, r_br, r_hlt;
        logic [INSTR_W-1:0] w;

        for (int i = 0; i < 1024; i++) mem[i] = i[INSTR_W-1:0];
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);

        //   rst st stl br tgt    hlt | ev pc     done addr
        add(0, 1, 0, 0, 0,     0,   0, 0,     0, 0);
        add(0, 0, 0, 0, 0,     0,   0, 0,     0, 0);
        add(0, 0, 0, 0, 0,     0,   1, 0,     0, 1);
        add(0, 0, 0, 0, 0,     0,   1, 1,     0, 2);
        add(0, 0, 0, 0, 0,     0,   1, 2,     0, 3);
        add(0, 0, 0, 0, 0,     0,   1, 3,     0, 4);
        add(0, 0, 1, 0, 0,     0,   1, 4,     0, 5);
        add(0, 0, 1, 0, 0,     0,   1, 4,     0, 5);
        add(0, 0, 1, 1, 1023,  1,   1, 4,     0, 5);
        add(0, 0, 0, 0, 0,     0,   1, 4,     0, 5);
        add(0, 1, 0, 0, 0,     0,   1, 5,     0, 6);
        add(0, 0, 0, 0, 0,     0,   1, 6,     0, 7);
        add(0, 0, 0, 1, 'h100, 0,   1, 7,     0, 8);
        add(0, 0, 0, 1, 5,     1,   0, 0,     0, 'h100);
        add(0, 0, 0, 0, 0,     0,   1, 'h100, 0, 'h101);
        add(0, 0, 0, 0, 0,     0,   1, 'h101, 0, 'h102);
        add(0, 0, 0, 1, 1022,  0,   1, 'h102, 0, 'h103);
        add(0, 0, 0, 0, 0,     0,   0, 0,     0, 1022);
        add(0, 0, 0, 0, 0,     0,   1, 1022,  0, 1023);
        add(0, 0, 0, 0, 0,     0,   1, 1023,  0, 0);
        add(0, 0, 0, 0, 0,     0,   1, 0,     0, 1);
        add(0, 0, 0, 1, 9,     0,   1, 1,     0, 2);
        add(0, 0, 0, 0, 0,     0,   0, 0,     0, 9);
        add(0, 0, 0, 1, 'h200, 1,   1, 9,     0, 10);
        add(0, 0, 0, 0, 0,     0,   0, 0,     1, 0);
        add(0, 1, 0, 0, 0,     0,   0, 0,     1, 0);
        add(0, 0, 0, 0, 0,     0,   0, 0,     0, 0);
        add(0, 0, 0, 0, 0,     0,   1, 0,     0, 1);
        add(0, 0, 1, 0, 0,     0,   1, 1,     0, 2);
        add(1, 0, 1, 0, 0,     0,   1, 1,     0, 2);
        add(0, 1, 0, 0, 0,     0,   0, 0,     0, 0);
        add(0, 0, 0, 0, 0,     0,   0, 0,     0, 0);
        add(0, 0, 0, 0, 0,     0,   1, 0,     0, 1);
        add(0, 0, 0, 0, 0,     0,   1, 1,     0, 2);

        repeat (3) @(negedge clk);

        foreach (vq[i]) begin
            @(negedge clk);
            chk($sformatf("row%0d valid", i), {31'd0, instr_valid}, {31'd0, vq[i].ev});
            chk($sformatf("row%0d done", i), {31'd0, done}, {31'd0, vq[i].ed});
            chk($sformatf("row%0d imem_addr", i), {22'd0, imem_addr}, {22'd0, vq[i].eaddr});
            if (vq[i].ev) begin
                w = mem[vq[i].epc];
                chk($sformatf("row%0d pc_out", i), {22'd0, pc_out}, {22'd0, vq[i].epc});
                chk($sformatf("row%0d instr", i), {23'd0, instr}, {23'd0, w});
                chk($sformatf("row%0d opcode", i), {29'd0, opcode}, {29'd0, w[8:6]});
            end
            drive(vq[i].rst, vq[i].st, vq[i].stl, vq[i].br, vq[i].tgt, vq[i].hlt);
        end

        // Randomized phase with fresh memory contents.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 1024; i++) mem[i] = INSTR_W'($urandom);
        m_mode = 0; m_pc = '0; m_bubble = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            ev = (m_mode == 1) && !m_bubble;
            chk($sformatf("rnd%0d valid", c), {31'd0, instr_valid}, {31'd0, ev});
            chk($sformatf("rnd%0d done", c), {31'd0, done}, {31'd0, (m_mode == 2)});
            if (m_mode != 1)
                chk($sformatf("rnd%0d imem_addr", c), {22'd0, imem_addr}, 32'd0);
            if (ev) begin
                w = mem[m_pc];
                chk($sformatf("rnd%0d pc_out", c), {22'd0, pc_out}, {22'd0, m_pc});
                chk($sformatf("rnd%0d instr", c), {23'd0, instr}, {23'd0, w});
                chk($sformatf("rnd%0d opcode", c), {29'd0, opcode}, {29'd0, w[8:6]});
            end
            r_rst = ($urandom_range(0, 199) == 0);
            r_st  = ($urandom_range(0, 9) == 0);
            r_stl = ($urandom_range(0, 9) < 3);
            r_br  = ($urandom_range(0, 9) == 0);
            r_hlt = ($urandom_range(0, 39) == 0);
            tgt   = ($urandom_range(0, 3) == 0) ? PC_W'(1020 + $urandom_range(0, 3))
                                                : PC_W'($urandom_range(0, 1023));
            drive(r_rst, r_st, r_stl, r_br, tgt, r_hlt);
            model_step(r_rst, r_st, r_stl, r_br, tgt, r_hlt);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
